// File: rtl/bch_enc.sv
// bch_enc: systematic BCH encoder; serial message in, codeword out as 64-bit beats of eight 8-bit samples.
// Optional BCH_ENC_LLR_EN: emit signed +/-LLR_MAG soft samples (LLR_MAG exists only in that build).
module bch_enc
`ifdef BCH_ENC_LLR_EN
#(
    parameter logic [7:0] LLR_MAG = 8'd64
)
`endif
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [1:0]  code,
    input  logic [39:0] gpoly,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] odata,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, MSG, OUT} state_t;
    state_t state, state_nxt;

    logic [1:0]    code_q;
    logic [39:0]   gpoly_q, par, par_nxt, rmask;
    logic [1023:0] cw;
    logic [9:0]    cnt, n, r, k;
    logic [7:0]    nbeat;
    logic [6:0]    j;
    logic [5:0]    rtop;
    logic          fb, take, last_bit, take_out, last_beat;

    function automatic logic [7:0] smp(input logic b);
`ifdef BCH_ENC_LLR_EN
        return b ? 8'(-LLR_MAG) : LLR_MAG;
`else
        return b ? 8'hFF : 8'h00;
`endif
    endfunction

    // Beat jv covers positions P-8jv..P-8jv-7; since P = 8*nb-1 the lowest is 8*(nb-1-jv).
    function automatic logic [63:0] beat(input logic [1023:0] v, input logic [7:0] nb, input logic [6:0] jv);
        logic [63:0] o;
        logic [9:0]  base;
        base = ({2'b00, nb} - 10'd1 - {3'b000, jv}) << 3;
        for (int b = 0; b < 8; b++) o[8*b +: 8] = smp(v[base + 10'(b)]);
        return o;
    endfunction

    always_comb begin
        case (code_q)
            2'd1:    begin n = 10'd63;   r = 10'd12; nbeat = 8'd8;   end
            2'd2:    begin n = 10'd255;  r = 10'd16; nbeat = 8'd32;  end
            default: begin n = 10'd1023; r = 10'd40; nbeat = 8'd128; end
        endcase
        k         = n - r;
        rtop      = 6'(r - 10'd1);
        rmask     = (40'd1 << r) - 40'd1;
        fb        = in_bit ^ par[rtop];
        par_nxt   = ({par[38:0], 1'b0} ^ (fb ? gpoly_q : 40'd0)) & rmask;
        take      = (state == MSG) && in_valid;
        last_bit  = take && (cnt == k - 10'd1);
        take_out  = (state == OUT) && out_ready;
        last_beat = take_out && ({1'b0, j} == nbeat - 8'd1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = MSG;
            MSG:     if (last_bit)  state_nxt = OUT;
            OUT:     if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == MSG);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_q  <= '0;
            gpoly_q <= '0;
            par     <= '0;
            cnt     <= '0;
            cw      <= '0;
            j       <= '0;
            odata   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    code_q  <= code;
                    gpoly_q <= gpoly;
                    par     <= '0;
                    cnt     <= '0;
                    cw      <= '0;  // also zeroes the pad bit above position n-1
                end
                MSG: if (take) begin
                    cw[n - 10'd1 - cnt] <= in_bit;
                    par <= par_nxt;
                    cnt <= cnt + 10'd1;
                    if (last_bit) begin
                        for (int i = 0; i < 40; i++)
                            if (10'(i) < r) cw[i] <= par_nxt[i];
                        j <= '0;
                        // Beat 0 holds only high message positions, all already stored.
                        odata <= beat(cw, nbeat, 7'd0);
                    end
                end
                OUT: if (take_out) begin
                    if (last_beat) begin
                        done  <= 1'b1;
                        odata <= '0;
                    end else begin
                        j     <= j + 7'd1;
                        odata <= beat(cw, nbeat, j + 7'd1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bch_enc.sv
// tb_bch_enc: directed encodes of every code through a scoreboard/monitor pair.
// A long-division reference plus a divisibility check on the received codeword stand in for the decoder.
`timescale 1ns/1ps
module tb_bch_enc;
    logic        clk = 0, rstn = 0, start = 0, in_valid = 0, in_bit = 0, out_ready = 1;
    logic [1:0]  code = 0;
    logic [39:0] gpoly = 0;
    logic        in_ready, out_valid, busy, done;
    logic [63:0] odata;

    bch_enc dut (.clk(clk), .rstn(rstn), .start(start), .code(code), .gpoly(gpoly),
                 .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
                 .out_valid(out_valid), .out_ready(out_ready), .odata(odata),
                 .busy(busy), .done(done));

    always #5 clk = ~clk;

`ifdef BCH_ENC_LLR_EN
    localparam logic [7:0] S1 = 8'hC0, S0 = 8'h40;
`else
    localparam logic [7:0] S1 = 8'hFF, S0 = 8'h00;
`endif

    int            tests = 0, fails = 0;
    logic [63:0]   sb[$];
    logic [1023:0] rx;
    int            rx_beat = 0, cur_p = 63, done_cnt = 0;
    bit            bp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] pat);
        logic [63:0] o;
        for (int b = 0; b < 8; b++) o[8*b +: 8] = pat[b] ? S1 : S0;
        return o;
    endfunction

    function automatic int fn_n(input logic [1:0] c);
        return (c == 2'd1) ? 63 : (c == 2'd2) ? 255 : 1023;
    endfunction

    function automatic int fn_r(input logic [1:0] c);
        return (c == 2'd1) ? 12 : (c == 2'd2) ? 16 : 40;
    endfunction

    // Remainder of v(x) mod g(x), g = x^r + sum gp[t] x^t; result in bits r-1..0.
    function automatic logic [1023:0] gf2_rem(input logic [1023:0] v, input int n, input int r,
                                             input logic [39:0] gp);
        logic [1023:0] w;
        w = v;
        for (int p = n - 1; p >= r; p--)
            if (w[p]) begin
                w[p] = 1'b0;
                for (int t = 0; t < r; t++) w[p-r+t] ^= gp[t];
            end
        return w;
    endfunction

    function automatic logic [1023:0] ref_cw(input logic [1:0] c, input logic [39:0] gp,
                                            input logic [1022:0] msg);
        int n = fn_n(c), r = fn_r(c);
        logic [1023:0] e, w;
        e = '0;
        for (int i = 0; i < n - r; i++) e[n-1-i] = msg[i];
        w = gf2_rem(e, n, r, gp);
        for (int t = 0; t < r; t++) e[t] = w[t];
        return e;
    endfunction

    task automatic push_model(input logic [1:0] c, input logic [39:0] gp, input logic [1022:0] msg);
        int nb = (fn_n(c) + 1) / 8;
        logic [1023:0] e;
        logic [63:0] o;
        e = ref_cw(c, gp, msg);
        for (int j = 0; j < nb; j++) begin
            for (int b = 0; b < 8; b++) o[8*b +: 8] = e[8*(nb-1-j)+b] ? S1 : S0;
            sb.push_back(o);
        end
    endtask

    task automatic wait_done(input string name);
        int c0 = done_cnt;
        int cyc = 0;
        while (done_cnt == c0 && cyc < 4000) begin
            @(posedge clk);
            cyc++;
        end
        check({name, "_done"}, 64'(done_cnt - c0), 64'd1);
        check({name, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic encode(input string name, input logic [1:0] c, input logic [39:0] gp,
                          input logic [1022:0] msg, input bit stall, input bit hold);
        int k = fn_n(c) - fn_r(c);
        int i = 0;
        rx = '0;
        rx_beat = 0;
        cur_p = fn_n(c);
        @(posedge clk); #1 in_valid = 1; in_bit = 1;  // stray bit in IDLE
        @(posedge clk); #1 start = 1; code = c; gpoly = gp; in_valid = 0;
        @(posedge clk); #1 start = hold;
        check({name, "_busy"}, 64'(busy), 64'd1);
        while (i < k) begin
            in_valid = !(stall && $urandom_range(0, 3) == 0);
            in_bit = msg[i];
            @(posedge clk); #1;
            if (in_valid) i++;
        end
        check({name, "_ready_drop"}, 64'({in_ready, out_valid}), 64'b01);
        in_valid = 1; in_bit = 1;  // stray bit in OUT
        @(posedge clk); #1 in_valid = 0; start = 0;
        wait_done(name);
    endtask

    initial forever begin
        @(posedge clk); #1;
        out_ready = bp ? ~out_ready : 1'b1;
    end

    // Monitor: pops expected beats on each handshake, checks stall stability and done width.
    initial begin
        logic [63:0] held;
        bit held_v = 0, done_prev = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                held_v = 0;
                done_prev = 0;
            end else begin
                if (held_v && out_valid) check("stall_hold", odata, held);
                held_v = out_valid && !out_ready;
                held = odata;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
                    else check("beat", odata, sb.pop_front());
                    for (int b = 0; b < 8; b++)
                        if (cur_p - 8*rx_beat - 7 + b >= 0) rx[cur_p - 8*rx_beat - 7 + b] = odata[8*b+7];
                    rx_beat++;
                end
                if (done) begin
                    check("done_single", 64'(done_prev), 64'd0);
                    done_cnt++;
                end
                done_prev = done;
            end
        end
    end

    initial begin
        logic [1022:0] m;
        logic [1023:0] w;
        logic [39:0] gp;
        int cyc;

        #3;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_odata", odata, 64'd0);
        @(posedge clk); @(posedge clk); #1 rstn = 1;

        // All-zero message with a zero generator; start held through MSG.
        for (int j = 0; j < 8; j++) sb.push_back(mk(8'h00));
        encode("zero", 2'd1, 40'h0, '0, 0, 1);

        // Single 1 in c[12]: parity = ABC; bits above r-1 of gpoly must be ignored.
        m = '0;
        m[50] = 1'b1;
        for (int j = 0; j < 6; j++) sb.push_back(mk(8'h00));
        sb.push_back(mk(8'b0001_1010));  // positions 15..8
        sb.push_back(mk(8'b1011_1100));  // positions 7..0
        encode("single", 2'd1, 40'h5A_5A5A_5ABC, m, 0, 0);

        // (255,239) under output backpressure and input stalls.
        for (int i = 0; i < 1023; i++) m[i] = 1'($urandom_range(0, 1));
        gp = 40'h00_0001_8005;
        push_model(2'd2, gp, m);
        bp = 1;
        encode("bp", 2'd2, gp, m, 1, 0);
        bp = 0;

        // (1023,983) loopback: received codeword must be a multiple of g(x), pad bit 0.
        for (int i = 0; i < 1023; i++) m[i] = 1'($urandom_range(0, 1));
        gp = 40'h96_3A5C_17E3;
        push_model(2'd3, gp, m);
        encode("loop", 2'd3, gp, m, 0, 0);
        w = gf2_rem(rx, 1023, 40, gp);
        check("loop_syndrome", {24'd0, w[39:0]}, 64'd0);
        check("loop_pad", 64'(rx[1023]), 64'd0);

        // code=0 selects the same (1023,983) code.
        for (int i = 0; i < 1023; i++) m[i] = 1'($urandom_range(0, 1));
        push_model(2'd3, gp, m);
        encode("code0", 2'd0, gp, m, 1, 0);

        // Reset while beat 3 is presented.
        for (int i = 0; i < 1023; i++) m[i] = 1'($urandom_range(0, 1));
        gp = 40'h00_0000_0805;
        push_model(2'd1, gp, m);
        rx_beat = 0;
        cur_p = 63;
        @(posedge clk); #1 start = 1; code = 2'd1; gpoly = gp;
        @(posedge clk); #1 start = 0;
        for (int i = 0; i < 51; i++) begin
            in_valid = 1;
            in_bit = m[i];
            @(posedge clk); #1;
        end
        in_valid = 0;
        cyc = 0;
        while (rx_beat < 3 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("abort_reached", 64'(rx_beat), 64'd3);
        #2 rstn = 0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_odata", odata, 64'd0);
        sb.delete();
        @(posedge clk); #1 rstn = 1;

        for (int i = 0; i < 1023; i++) m[i] = 1'($urandom_range(0, 1));
        push_model(2'd1, gp, m);
        encode("fresh", 2'd1, gp, m, 0, 0);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
